// File: rtl/note_player_if.sv
// rtl/note_player_if.sv - note code valid/ready handshake between playback controller and note_player
interface note_player_if;
  logic [5:0] note_in;
  logic       note_valid;
  logic       note_ready;

  modport master (output note_in, output note_valid, input note_ready);
  modport slave  (input note_in, input note_valid, output note_ready);
endinterface

// File: rtl/note_player.sv
// rtl/note_player.sv - renders one {octave,note} code as a square wave for a fixed time, then a silent gap
module note_player #(
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  note_player_if.slave        note_bus,
  input  logic                stop,
  output logic                audio_out,
  output logic                busy,
  output logic [5:0]          note_active
);
  localparam int CMAX = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t      r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [21:0] r_tone_cnt, w_tone_nxt;
  logic        r_audio, w_audio_nxt;
  logic [5:0]  r_active, w_active_nxt;
  logic        w_xfer;
  logic [21:0] w_half_load;

  // Octave 4 is the reference; other octaves are truncating power-of-two shifts of it.
  function automatic logic [21:0] half_period(input logic [5:0] code);
    logic [21:0] base;
    case (code[2:0])
      3'd1:    base = 22'd191113;
      3'd2:    base = 22'd170262;
      3'd3:    base = 22'd151686;
      3'd4:    base = 22'd143173;
      3'd5:    base = 22'd127553;
      3'd6:    base = 22'd113636;
      3'd7:    base = 22'd101239;
      default: base = 22'd0;
    endcase
    if (code[5])
      return base >> code[4:3];
    else
      return base << (3'd4 - code[5:3]);
  endfunction

  assign note_bus.note_ready = (r_state == S_IDLE) && !stop;
  assign w_xfer              = note_bus.note_valid && note_bus.note_ready;
  assign w_half_load         = half_period(note_bus.note_in) - 22'd1;

  assign audio_out   = r_audio;
  assign note_active = r_active;
  assign busy        = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tone_cnt <= '0;
      r_audio    <= 1'b0;
      r_active   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tone_cnt <= w_tone_nxt;
      r_audio    <= w_audio_nxt;
      r_active   <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_tone_nxt   = r_tone_cnt;
    w_audio_nxt  = r_audio;
    w_active_nxt = r_active;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_active_nxt = note_bus.note_in;
          w_cnt_nxt    = NOTE_LOAD;
          w_tone_nxt   = w_half_load;
          w_audio_nxt  = 1'b0;
          w_state_nxt  = S_PLAY;
        end
      end
      S_PLAY: begin
        if (stop) begin
          w_state_nxt  = S_IDLE;
          w_cnt_nxt    = '0;
          w_tone_nxt   = '0;
          w_audio_nxt  = 1'b0;
          w_active_nxt = '0;
        end else if (r_cnt == '0) begin
          // Exit wins over a coincident toggle, so the last partial half-period is cut short.
          w_audio_nxt  = 1'b0;
          w_active_nxt = '0;
          w_tone_nxt   = '0;
          if (GAP_CYCLES > 0) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = GAP_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_active[2:0] != 3'd0) begin
            if (r_tone_cnt == 22'd0) begin
              w_tone_nxt  = half_period(r_active) - 22'd1;
              w_audio_nxt = ~r_audio;
            end else begin
              w_tone_nxt = r_tone_cnt - 22'd1;
            end
          end
        end
      end
      S_GAP: begin
        w_audio_nxt = 1'b0;
        if (stop || r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_cnt_nxt    = '0;
        w_tone_nxt   = '0;
        w_audio_nxt  = 1'b0;
        w_active_nxt = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_note_player.sv
// tb/tb_note_player.sv - randomized scoreboard bench for note_player output transitions
module tb_note_player;
  localparam int N = 30000;
  localparam int G = 16;
  localparam int K_AUDIO = 0, K_ACTIVE = 1, K_BUSY = 2, K_READY = 3;

  typedef struct {int cyc; int kind; int val;} ev_t;

  logic       clk, rst, stop, audio_out, busy;
  logic [5:0] note_active;
  int         cyc = 0;
  int         vectors = 0, miscompares = 0;
  ev_t        exp_q[$];

  note_player_if bus();

  note_player #(.NOTE_CYCLES(N), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .note_bus(bus), .stop(stop),
    .audio_out(audio_out), .busy(busy), .note_active(note_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_AUDIO:  return "audio_out";
      K_ACTIVE: return "note_active";
      K_BUSY:   return "busy";
      default:  return "note_ready";
    endcase
  endfunction

  function automatic int half_of(logic [5:0] code);
    int base[8] = '{0, 191113, 170262, 151686, 143173, 127553, 113636, 101239};
    int o = int'(code[5:3]);
    int b = base[code[2:0]];
    if (o >= 4) return b >> (o - 4);
    return b << (4 - o);
  endfunction

  function automatic void push(int c, int k, int v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    exp_q.push_back(e);
  endfunction

  // Expected output transitions for a code accepted at edge k; ending early at edge s unless full.
  function automatic void model_note(int k, logic [5:0] c, int s, bit full);
    int h = half_of(c);
    int pe = full ? k + N : s;
    int a = 0;
    if (c != 6'd0) push(k, K_ACTIVE, int'(c));
    push(k, K_BUSY, 1);
    push(k, K_READY, 0);
    if (c[2:0] != 3'd0)
      for (int t = k + h; t < pe; t += h) begin
        a = 1 - a;
        push(t, K_AUDIO, a);
      end
    if (a == 1) push(pe, K_AUDIO, 0);
    if (c != 6'd0) push(pe, K_ACTIVE, 0);
    if (!full || G == 0) begin
      push(pe, K_BUSY, 0);
      push(pe, K_READY, 1);
    end else begin
      push(k + N + G, K_BUSY, 0);
      push(k + N + G, K_READY, 1);
    end
  endfunction

  task automatic check_ev(int kind, int val);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected %s change at cyc %0d: got %0d, none required", kname(kind), cyc, val);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val != val) begin
        miscompares++;
        $display("FAIL event: got %s=%0d at cyc %0d, required %s=%0d at cyc %0d",
                 kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
      end
    end
  endtask

  task automatic check_rst(string name, int got, int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL reset %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin : monitor
    logic p_audio, p_busy, p_ready;
    logic [5:0] p_active;
    @(negedge clk);
    check_rst("audio_out", int'(audio_out), 0);
    check_rst("note_active", int'(note_active), 0);
    check_rst("busy", int'(busy), 0);
    check_rst("note_ready", int'(bus.note_ready), 1);
    p_audio = audio_out; p_active = note_active; p_busy = busy; p_ready = bus.note_ready;
    forever begin
      @(negedge clk);
      if (audio_out !== p_audio)        check_ev(K_AUDIO, int'(audio_out));
      if (note_active !== p_active)     check_ev(K_ACTIVE, int'(note_active));
      if (busy !== p_busy)              check_ev(K_BUSY, int'(busy));
      if (bus.note_ready !== p_ready)   check_ev(K_READY, int'(bus.note_ready));
      p_audio = audio_out; p_active = note_active; p_busy = busy; p_ready = bus.note_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick();
  endtask

  task automatic play_stopped(logic [5:0] c, int sa, bit use_rst);
    int k = cyc + 1;
    bus.note_in = c; bus.note_valid = 1'b1;
    model_note(k, c, k + sa, 1'b0);
    tick();
    bus.note_valid = 1'b0;
    if (use_rst) begin
      wait_until(k + sa);
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end else begin
      wait_until(k + sa - 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
    end
  endtask

  initial begin : stimulus
    logic [5:0] c1, c2;
    int k1, k2, sa;
    rst = 1'b0; stop = 1'b0; bus.note_valid = 1'b0; bus.note_in = 6'd0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick(); tick();

    // stop together with valid in IDLE: only note_ready dips, nothing is accepted
    stop = 1'b1; bus.note_valid = 1'b1; bus.note_in = 6'($urandom_range(1, 63));
    push(cyc, K_READY, 0);
    tick();
    stop = 1'b0; bus.note_valid = 1'b0;
    push(cyc, K_READY, 1);
    tick(); tick();

    // full octave-7 tone, then a second code held back-to-back and aborted
    c1 = {3'd7, 3'($urandom_range(1, 7))};
    c2 = 6'($urandom);
    sa = $urandom_range(200, 800);
    bus.note_in = c1; bus.note_valid = 1'b1;
    k1 = cyc + 1;
    model_note(k1, c1, 0, 1'b1);
    tick();
    bus.note_in = c2;
    k2 = k1 + N + G + 1;
    model_note(k2, c2, k2 + sa, 1'b0);
    wait_until(k2);
    bus.note_valid = 1'b0;
    wait_until(k2 + sa - 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // abort octave-7 B after its first toggle, while audio_out is high
    play_stopped({3'd7, 3'd7}, $urandom_range(12655, 15600), 1'b0);
    tick();

    for (int i = 0; i < 8; i++) begin
      play_stopped(6'($urandom), $urandom_range(20, 1500), 1'b0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    play_stopped(6'($urandom), $urandom_range(50, 500), 1'b1);
    tick();
    play_stopped({3'd4, 3'd5}, $urandom_range(30, 300), 1'b0);

    repeat (20) tick();
    while (exp_q.size() > 0) begin
      ev_t e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing %s=%0d at cyc %0d", kname(e.kind), e.val, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/note_player.md
# note_player

Playback-side consumer of the piano's 6-bit recorded note codes {octave[2:0], note[2:0]}. It accepts one code at a time over a valid/ready handshake and renders it as a square wave on a single audio pin for a fixed duration, followed by a fixed silent gap. It sits between the record/playback controller and the speaker output, at the 100 MHz system clock.

## Interface

- NOTE_CYCLES, 25_000_000: tone duration per accepted code, in clk cycles (≥1).
- GAP_CYCLES, 1_000_000: forced silence after each tone, in clk cycles (0 allowed = no gap).
- clk  input  1  100 MHz system clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- note_in  input  6  code: [5:3] octave 0–7, [2:0] note 0=rest, 1–7 = C D E F G A B.
- note_valid  input  1  note_in is valid this cycle.
- note_ready  output  1  block can accept a code this cycle.
- stop  input  1  synchronous abort of current tone/gap.
- audio_out  output  1  square-wave speaker drive.
- busy  output  1  high in PLAY or GAP.
- note_active  output  6  code currently sounding; 0 outside PLAY.

## Operation

- FSM states IDLE, PLAY, GAP. Reset: IDLE, audio_out=0, note_active=0, busy=0, all counters 0.
- note_ready = (state==IDLE) && !stop, combinational. Transfer on posedge when note_valid && note_ready.
- IDLE: on transfer latch note_in into note_active, load dur_cnt=NOTE_CYCLES-1, load tone_cnt=half_period-1, audio_out=0, go PLAY.
- Half-period table (octave 4, cycles at 100 MHz): C 191113, D 170262, E 151686, F 143173, G 127553, A 113636, B 101239. Octave o≥4: base >> (o-4); o<4: base << (4-o). Truncating shifts. 22-bit tone counter (octave 0 C = 3,057,808 fits).
- PLAY: dur_cnt decrements every cycle. tone_cnt decrements; at 0 reload half_period-1 and toggle audio_out — only when note≠0. Rest (note=0, any octave): audio_out stays 0 for full duration.
- PLAY exit when dur_cnt==0: audio_out←0, note_active←0; go GAP (load GAP_CYCLES-1) if GAP_CYCLES>0, else IDLE.
- GAP: audio_out held 0; decrement; at 0 go IDLE.
- stop high in PLAY or GAP: next edge → IDLE, audio_out=0, note_active=0, counters cleared. stop in IDLE: no transfer (ready low), stays IDLE.
- note_valid while not ready is ignored; sender must hold code until ready (no internal buffering).
- rst asserted anywhere: immediate return to reset values, independent of clk.

## Timing

- Transfer at edge k: state=PLAY, busy=1, note_active valid after edge k.
- First audio toggle at edge k+half_period; subsequent toggles every half_period edges.
- PLAY occupies NOTE_CYCLES cycles: exit edge k+NOTE_CYCLES. IDLE re-entered at edge k+NOTE_CYCLES+GAP_CYCLES; note_ready high in the following cycle, so back-to-back codes start every NOTE_CYCLES+GAP_CYCLES+1 cycles at best.
- Partial final half-period is truncated at PLAY exit; audio_out always 0 in GAP and IDLE.
- Default period: 0.25 s tone + 10 ms gap per code.

## Test plan

- Reset: assert rst mid-simulation asynchronously → audio_out=0, note_active=0, busy=0, note_ready=1 before next edge.
- NOTE_CYCLES=500000, GAP_CYCLES=1000; send 6'b100_110 (oct 4, A) → toggles at +113636, +227272, +340908, +454544; audio_out=0 from +500000; note_ready high again after +501000.
- Octave scaling: send 6'b111_110 (oct 7, A) → toggle spacing 14204; 6'b001_001 (oct 1, C) → spacing 1528904, no toggle within 500000.
- Rest: send 6'b100_000 → audio_out 0 throughout, busy high for 501000 cycles, note_active=6'b100_000 during PLAY.
- Back-to-back: hold note_valid with codes C4 then E4 → second accepted exactly one cycle after IDLE re-entry; note_ready low for 501000 cycles between transfers; no code lost or duplicated.
- stop at +200000 into G4, and stop asserted together with note_valid in IDLE → IDLE on next edge, audio_out=0; simultaneous case: no transfer, note_active stays 0.
